// File: rtl/wb_fuzz_bridge_v2_if.sv
// Bus bundle for the fuzzer bridge: Wishbone master side, Wishbone slave side and
// the fuzzer command/report side. The "master" modport is the bridge's own view.
interface wb_fuzz_bridge_v2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int EW = MAX_BURST * DATA_WIDTH;
    localparam int LW = $clog2(MAX_BURST + 1);

    logic                  wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [ADDR_WIDTH-1:0] wbm_adr_o;
    logic [DATA_WIDTH-1:0] wbm_dat_o;
    logic [SW-1:0]         wbm_sel_o;
    logic [2:0]            wbm_cti_o;
    logic [1:0]            wbm_bte_o;
    logic [DATA_WIDTH-1:0] wbm_dat_i;
    logic                  wbm_ack_i, wbm_err_i;

    logic                  wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [ADDR_WIDTH-1:0] wbs_adr_i;
    logic [DATA_WIDTH-1:0] wbs_dat_i;
    logic [SW-1:0]         wbs_sel_i;
    logic [2:0]            wbs_cti_i;
    logic [DATA_WIDTH-1:0] wbs_dat_o;
    logic                  wbs_ack_o, wbs_err_o;

    // Command handshake: a command is taken on any clock edge where ext_m_req and
    // ext_m_ready are both high; ext_m_done/ext_s_valid are single-cycle pulses
    // with no back-pressure, their payloads hold until the next pulse.
    logic                  ext_m_req, ext_m_ready, ext_m_we;
    logic [ADDR_WIDTH-1:0] ext_m_addr;
    logic [LW-1:0]         ext_m_len;
    logic [SW-1:0]         ext_m_sel;
    logic [EW-1:0]         ext_m_wdata, ext_m_rdata;
    logic                  ext_m_done, ext_m_err;
    logic [LW-1:0]         ext_m_beats;
    logic [EW-1:0]         ext_s_rdata;
    logic                  ext_s_valid, ext_s_we;
    logic [ADDR_WIDTH-1:0] ext_s_addr;
    logic [LW-1:0]         ext_s_len;
    logic [EW-1:0]         ext_s_wdata;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_cti_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o,
        input  ext_m_req, ext_m_we, ext_m_addr, ext_m_len, ext_m_sel, ext_m_wdata, ext_s_rdata,
        output ext_m_ready, ext_m_rdata, ext_m_done, ext_m_err, ext_m_beats,
        output ext_s_valid, ext_s_we, ext_s_addr, ext_s_len, ext_s_wdata
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_cti_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o,
        output ext_m_req, ext_m_we, ext_m_addr, ext_m_len, ext_m_sel, ext_m_wdata, ext_s_rdata,
        input  ext_m_ready, ext_m_rdata, ext_m_done, ext_m_err, ext_m_beats,
        input  ext_s_valid, ext_s_we, ext_s_addr, ext_s_len, ext_s_wdata
    );
endinterface

// File: rtl/wb_fuzz_bridge_v2.sv
// Dual-role Wishbone B4 bridge: fuzzer-driven burst master with timeout watchdog,
// plus a burst slave that captures DUT transactions and reports them to the fuzzer.
module wb_fuzz_bridge_v2 #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BURST      = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    wb_fuzz_bridge_v2_if.master       bus,
    output logic [1:0]                o_dbg_m_state,
    output logic [1:0]                o_dbg_s_state
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int EW = MAX_BURST * DATA_WIDTH;
    localparam int LW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BURST);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {M_IDLE = 2'd0, M_BUS = 2'd1, M_DONE = 2'd2} m_state_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_REPORT = 2'd2} s_state_t;

    m_state_t              r_m_state, w_m_next;
    logic                  r_m_we;
    logic [ADDR_WIDTH-1:0] r_m_adr;
    logic [LW-1:0]         r_m_len, r_m_idx, w_m_len_clamped;
    logic [SW-1:0]         r_m_sel;
    logic [EW-1:0]         r_m_wdata, r_m_rbuf, w_m_rbuf_next;
    logic [TW-1:0]         r_m_tcnt;
    logic [EW-1:0]         r_m_out_rdata;
    logic                  r_m_out_err;
    logic [LW-1:0]         r_m_out_beats;
    logic                  w_m_busy, w_m_last, w_m_ack, w_m_abort;

    always_comb begin
        w_m_len_clamped = bus.ext_m_len;
        if (bus.ext_m_len == '0)
            w_m_len_clamped = LW'(1);
        else if (bus.ext_m_len > MAX_LEN)
            w_m_len_clamped = MAX_LEN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_m_state <= M_IDLE;
        else     r_m_state <= w_m_next;
    end

    always_comb begin
        w_m_next  = r_m_state;
        w_m_busy  = 1'b0;
        w_m_ack   = 1'b0;
        w_m_abort = 1'b0;
        w_m_last  = (r_m_idx == r_m_len - LW'(1));
        case (r_m_state)
            M_IDLE: if (bus.ext_m_req) w_m_next = M_BUS;
            M_BUS: begin
                w_m_busy = 1'b1;
                // ERR beats ACK; an ACK in the last watchdog cycle still counts.
                w_m_abort = bus.wbm_err_i || (!bus.wbm_ack_i && r_m_tcnt == TO_LAST);
                w_m_ack   = bus.wbm_ack_i && !bus.wbm_err_i;
                if (w_m_abort || (w_m_ack && w_m_last)) w_m_next = M_DONE;
            end
            M_DONE:  w_m_next = M_IDLE;
            default: w_m_next = M_IDLE;
        endcase
    end

    always_comb begin
        w_m_rbuf_next = r_m_rbuf;
        if (w_m_ack && !r_m_we) begin
            for (int i = 0; i < MAX_BURST; i++)
                if (r_m_idx == LW'(i)) w_m_rbuf_next[i*DATA_WIDTH +: DATA_WIDTH] = bus.wbm_dat_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_we        <= 1'b0;
            r_m_adr       <= '0;
            r_m_len       <= '0;
            r_m_idx       <= '0;
            r_m_sel       <= '1;
            r_m_wdata     <= '0;
            r_m_rbuf      <= '0;
            r_m_tcnt      <= '0;
            r_m_out_rdata <= '0;
            r_m_out_err   <= 1'b0;
            r_m_out_beats <= '0;
        end else begin
            case (r_m_state)
                M_IDLE: if (bus.ext_m_req) begin
                    r_m_we    <= bus.ext_m_we;
                    r_m_adr   <= bus.ext_m_addr;
                    r_m_len   <= w_m_len_clamped;
                    r_m_sel   <= bus.ext_m_sel;
                    r_m_wdata <= bus.ext_m_wdata;
                    r_m_rbuf  <= '0;
                    r_m_idx   <= '0;
                    r_m_tcnt  <= '0;
                end
                M_BUS: begin
                    if (w_m_abort) begin
                        r_m_out_err   <= 1'b1;
                        r_m_out_beats <= r_m_idx;
                        r_m_out_rdata <= r_m_rbuf;
                    end else if (w_m_ack) begin
                        r_m_rbuf  <= w_m_rbuf_next;
                        r_m_idx   <= r_m_idx + LW'(1);
                        r_m_adr   <= r_m_adr + ADDR_WIDTH'(SW);
                        // Current write beat always sits in the low word.
                        r_m_wdata <= r_m_wdata >> DATA_WIDTH;
                        r_m_tcnt  <= '0;
                        if (w_m_last) begin
                            r_m_out_err   <= 1'b0;
                            r_m_out_beats <= r_m_idx + LW'(1);
                            r_m_out_rdata <= w_m_rbuf_next;
                        end
                    end else begin
                        r_m_tcnt <= r_m_tcnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wbm_cyc_o   = w_m_busy;
    assign bus.wbm_stb_o   = w_m_busy;
    assign bus.wbm_we_o    = w_m_busy & r_m_we;
    assign bus.wbm_adr_o   = r_m_adr;
    assign bus.wbm_dat_o   = r_m_wdata[DATA_WIDTH-1:0];
    assign bus.wbm_sel_o   = r_m_sel;
    assign bus.wbm_cti_o   = w_m_busy ? (w_m_last ? 3'b111 : 3'b010) : 3'b000;
    assign bus.wbm_bte_o   = 2'b00;
    assign bus.ext_m_ready = (r_m_state == M_IDLE);
    assign bus.ext_m_done  = (r_m_state == M_DONE);
    assign bus.ext_m_err   = r_m_out_err;
    assign bus.ext_m_beats = r_m_out_beats;
    assign bus.ext_m_rdata = r_m_out_rdata;
    assign o_dbg_m_state   = r_m_state;

    s_state_t              r_s_state, w_s_next;
    logic                  r_s_ack, r_s_err, r_s_we;
    logic [ADDR_WIDTH-1:0] r_s_adr;
    logic [LW-1:0]         r_s_idx, w_s_idx;
    logic [EW-1:0]         r_s_cap, w_s_cap_next;
    logic [DATA_WIDTH-1:0] r_s_dat;
    logic                  r_s_out_we;
    logic [ADDR_WIDTH-1:0] r_s_out_adr;
    logic [LW-1:0]         r_s_out_len;
    logic [EW-1:0]         r_s_out_wdata;
    logic                  w_s_first, w_s_we, w_s_accept, w_s_over, w_s_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_s_state <= S_IDLE;
        else     r_s_state <= w_s_next;
    end

    always_comb begin
        w_s_next     = r_s_state;
        w_s_first    = (r_s_state == S_IDLE);
        w_s_idx      = w_s_first ? '0 : r_s_idx;
        w_s_we       = w_s_first ? bus.wbs_we_i : r_s_we;
        w_s_accept   = bus.wbs_cyc_i && bus.wbs_stb_i && !r_s_ack && !r_s_err
                       && (r_s_state != S_REPORT);
        w_s_over     = (w_s_idx == MAX_LEN);
        w_s_end      = (bus.wbs_cti_i == 3'b000) || (bus.wbs_cti_i == 3'b111);
        w_s_cap_next = w_s_first ? '0 : r_s_cap;
        if (w_s_accept && !w_s_over && w_s_we) begin
            for (int i = 0; i < MAX_BURST; i++)
                for (int b = 0; b < SW; b++)
                    if (w_s_idx == LW'(i) && bus.wbs_sel_i[b])
                        w_s_cap_next[i*DATA_WIDTH + b*8 +: 8] = bus.wbs_dat_i[b*8 +: 8];
        end
        case (r_s_state)
            S_IDLE:   if (w_s_accept) w_s_next = w_s_end ? S_REPORT : S_ACTIVE;
            S_ACTIVE: begin
                if (w_s_accept)         w_s_next = (w_s_over || w_s_end) ? S_REPORT : S_ACTIVE;
                else if (!bus.wbs_cyc_i) w_s_next = S_REPORT;
            end
            S_REPORT: w_s_next = S_IDLE;
            default:  w_s_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_ack       <= 1'b0;
            r_s_err       <= 1'b0;
            r_s_we        <= 1'b0;
            r_s_adr       <= '0;
            r_s_idx       <= '0;
            r_s_cap       <= '0;
            r_s_dat       <= '0;
            r_s_out_we    <= 1'b0;
            r_s_out_adr   <= '0;
            r_s_out_len   <= '0;
            r_s_out_wdata <= '0;
        end else begin
            r_s_ack <= 1'b0;
            r_s_err <= 1'b0;
            if (w_s_accept) begin
                if (w_s_first) begin
                    r_s_we  <= bus.wbs_we_i;
                    r_s_adr <= bus.wbs_adr_i;
                end
                r_s_cap <= w_s_cap_next;
                if (w_s_over) begin
                    r_s_err <= 1'b1;
                end else begin
                    r_s_ack <= 1'b1;
                    r_s_idx <= w_s_idx + LW'(1);
                    if (!w_s_we) begin
                        for (int i = 0; i < MAX_BURST; i++)
                            if (w_s_idx == LW'(i)) r_s_dat <= bus.ext_s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            // Report payload is loaded on the edge that enters S_REPORT.
            if (w_s_next == S_REPORT && r_s_state != S_REPORT) begin
                r_s_out_we    <= w_s_we;
                r_s_out_adr   <= w_s_first ? bus.wbs_adr_i : r_s_adr;
                r_s_out_wdata <= w_s_cap_next;
                r_s_out_len   <= w_s_over ? MAX_LEN : (w_s_accept ? w_s_idx + LW'(1) : r_s_idx);
            end
        end
    end

    assign bus.wbs_ack_o   = r_s_ack;
    assign bus.wbs_err_o   = r_s_err;
    assign bus.wbs_dat_o   = r_s_dat;
    assign bus.ext_s_valid = (r_s_state == S_REPORT);
    assign bus.ext_s_we    = r_s_out_we;
    assign bus.ext_s_addr  = r_s_out_adr;
    assign bus.ext_s_len   = r_s_out_len;
    assign bus.ext_s_wdata = r_s_out_wdata;
    assign o_dbg_s_state   = r_s_state;
endmodule

// File: tb/tb_wb_fuzz_bridge_v2.sv
// Self-checking bench for wb_fuzz_bridge_v2: directed scenarios plus randomized
// master/slave bursts compared against a transaction-level model.
module tb_wb_fuzz_bridge_v2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 8;
    localparam int TO = 16;
    localparam int SW = DW / 8;
    localparam int EW = MB * DW;
    localparam int LW = $clog2(MB + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_m_state, dbg_s_state;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [71:0] exp_q[$];

    wb_fuzz_bridge_v2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) bus ();

    wb_fuzz_bridge_v2 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_dbg_m_state(dbg_m_state), .o_dbg_s_state(dbg_s_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic master_xfer(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                               input logic [SW-1:0] sel, input logic [EW-1:0] wdata,
                               input int err_beat, input bit no_ack, input int max_wait,
                               input bit fix_rd, input logic [DW-1:0] rd_val);
        int n, exp_beats, beat, waits, cyc_cnt, guard;
        logic exp_err;
        logic [EW-1:0] exp_rdata;
        logic [71:0] e, o;
        logic [DW-1:0] rd, wbeat;
        bit new_beat, got_done;
        n = (len == 0) ? 1 : ((int'(len) > MB) ? MB : int'(len));
        for (int i = 0; i < n; i++) begin
            wbeat = we ? wdata[i*DW +: DW] : '0;
            exp_q.push_back({we, sel, addr + AW'(i * SW), wbeat, (i == n - 1) ? 3'b111 : 3'b010});
        end
        exp_rdata = '0; exp_err = no_ack; exp_beats = 0;
        guard = 0;
        while (!bus.ext_m_ready && guard < 100) begin @(negedge clk); guard++; end
        check("m_ready", bus.ext_m_ready, 1);
        bus.ext_m_req = 1'b1; bus.ext_m_we = we; bus.ext_m_addr = addr; bus.ext_m_len = len;
        bus.ext_m_sel = sel; bus.ext_m_wdata = wdata;
        @(negedge clk);
        bus.ext_m_req = 1'b0;
        check("m_ready_fall", bus.ext_m_ready, 0);
        beat = 0; cyc_cnt = 0; new_beat = 1; got_done = 0;
        waits = $urandom_range(0, max_wait);
        for (int c = 0; c < 400; c++) begin
            if (c > 0) @(negedge clk);
            bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
            if (bus.ext_m_done) begin got_done = 1; break; end
            if (bus.wbm_cyc_o) begin
                cyc_cnt++;
                if (new_beat) begin
                    o = {bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o, we ? bus.wbm_dat_o : '0, bus.wbm_cti_o};
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                    check("m_beat", o, e);
                    new_beat = 0;
                end
                if (!no_ack) begin
                    if (waits == 0) begin
                        if (beat == err_beat) begin
                            bus.wbm_err_i = 1'b1; exp_err = 1'b1;
                            bus.wbm_ack_i = ($urandom_range(0, 1) == 1);
                        end else begin
                            rd = fix_rd ? rd_val : $urandom;
                            bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = rd;
                            if (!we) exp_rdata[beat*DW +: DW] = rd;
                            exp_beats++;
                        end
                        beat++; new_beat = 1; waits = $urandom_range(0, max_wait);
                    end else waits--;
                end
            end
        end
        exp_q.delete();
        check("m_done_seen", got_done, 1);
        check("m_cyc_at_done", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
        check("m_done_err", bus.ext_m_err, exp_err);
        check("m_done_beats", bus.ext_m_beats, exp_beats);
        check("m_done_rdata", bus.ext_m_rdata, exp_rdata);
        if (no_ack) check("m_timeout_cycles", cyc_cnt, TO);
        @(negedge clk);
        check("m_done_pulse", {bus.ext_m_done, bus.ext_m_ready}, 2'b01);
    endtask

    // term: 0 = cti 111 ends, 1 = cti 000 ends, 2 = cyc dropped, 3 = overflow past MB
    task automatic slave_xfer(input logic we, input logic [AW-1:0] addr, input int nbeats,
                              input int term, input logic [EW-1:0] wd, input logic [MB*SW-1:0] sl);
        logic [EW-1:0] exp_wdata;
        logic [DW-1:0] d;
        int exp_len, k;
        bit found;
        if (term == 3) nbeats = MB + 1;
        exp_len = (term == 3) ? MB : nbeats;
        exp_wdata = '0;
        if (we)
            for (int i = 0; i < exp_len; i++)
                for (int b = 0; b < SW; b++)
                    if (sl[i*SW + b]) exp_wdata[i*DW + b*8 +: 8] = wd[i*DW + b*8 +: 8];
        for (int i = 0; i < nbeats; i++) begin
            if (i < MB) d = wd[i*DW +: DW];
            else d = $urandom;
            bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
            bus.wbs_adr_i = addr + AW'(i * SW); bus.wbs_dat_i = d;
            bus.wbs_sel_i = (i < MB) ? sl[i*SW +: SW] : '1;
            bus.wbs_cti_i = (i == nbeats - 1 && term == 0) ? 3'b111 :
                            (i == nbeats - 1 && term == 1) ? 3'b000 : 3'b010;
            k = 0;
            do begin @(negedge clk); k++; end
            while (!bus.wbs_ack_o && !bus.wbs_err_o && k < 50);
            if (i == MB) check("s_err_beat", {bus.wbs_ack_o, bus.wbs_err_o}, 2'b01);
            else         check("s_ack_beat", {bus.wbs_ack_o, bus.wbs_err_o}, 2'b10);
            if (!we && i < MB) check("s_rdat", bus.wbs_dat_o, bus.ext_s_rdata[i*DW +: DW]);
            if (i < nbeats - 1 && $urandom_range(0, 3) == 0) begin
                bus.wbs_stb_i = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.ext_s_valid) begin found = 1; break; end
            @(negedge clk);
        end
        check("s_valid_seen", found, 1);
        check("s_rep_hdr", {bus.ext_s_we, bus.ext_s_addr, bus.ext_s_len}, {we, addr, LW'(exp_len)});
        check("s_rep_wdata", bus.ext_s_wdata, exp_wdata);
        @(negedge clk);
        check("s_valid_pulse", bus.ext_s_valid, 0);
    endtask

    function automatic logic [EW-1:0] rand_ew();
        logic [EW-1:0] v;
        for (int i = 0; i < MB; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [EW-1:0] wd, rp;
        logic [MB*SW-1:0] sl;
        int n, eb;
        bit saw_done;
        rst = 1'b1;
        bus.wbm_dat_i = '0; bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0; bus.wbs_sel_i = '0; bus.wbs_cti_i = '0;
        bus.ext_m_req = 1'b0; bus.ext_m_we = 1'b0; bus.ext_m_addr = '0; bus.ext_m_len = '0;
        bus.ext_m_sel = '0; bus.ext_m_wdata = '0; bus.ext_s_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_wbm", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o,
                          bus.wbm_sel_o, bus.wbm_cti_o, bus.wbm_bte_o}, {3'b0, 64'd0, 4'hF, 5'd0});
        check("rst_wbs", {bus.wbs_dat_o, bus.wbs_ack_o, bus.wbs_err_o}, 0);
        check("rst_ext_m", {bus.ext_m_ready, bus.ext_m_done, bus.ext_m_err, bus.ext_m_beats}, {1'b1, 6'd0});
        check("rst_ext_m_rdata", bus.ext_m_rdata, 0);
        check("rst_ext_s", {bus.ext_s_valid, bus.ext_s_we, bus.ext_s_addr, bus.ext_s_len}, 0);
        check("rst_ext_s_wdata", bus.ext_s_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        wd = '0;
        for (int i = 0; i < 4; i++) wd[i*DW +: DW] = 32'hA0 + i;
        master_xfer(1'b1, 32'h1000, 4, 4'hF, wd, -1, 0, 0, 0, '0);
        master_xfer(1'b0, 32'hFFFF_FFFC, 1, 4'hF, '0, -1, 0, 0, 1, 32'h5A5A_5A5A);
        master_xfer(1'b0, 32'h2000, 8, 4'hF, '0, 3, 0, 1, 0, '0);
        master_xfer(1'b1, 32'h3000, 2, 4'hF, rand_ew(), -1, 1, 0, 0, '0);
        master_xfer(1'b1, 32'hFFFF_FFF8, 3, 4'h5, rand_ew(), -1, 0, 2, 0, '0);
        master_xfer(1'b0, 32'h4000, 0, 4'hF, '0, -1, 0, 0, 0, '0);
        master_xfer(1'b0, 32'h5000, 13, 4'hA, '0, -1, 0, 1, 0, '0);

        // Reset in the middle of a stalled write burst.
        bus.ext_m_req = 1'b1; bus.ext_m_we = 1'b1; bus.ext_m_addr = 32'h6000; bus.ext_m_len = 4;
        @(negedge clk);
        bus.ext_m_req = 1'b0;
        repeat (4) @(negedge clk);
        check("m_cyc_pre_rst", bus.wbm_cyc_o, 1);
        rst = 1'b1;
        #1;
        check("m_rst_bus", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
        check("m_rst_ready", bus.ext_m_ready, 1);
        saw_done = 0;
        repeat (3) begin @(negedge clk); saw_done |= bus.ext_m_done; end
        rst = 1'b0;
        repeat (2) begin @(negedge clk); saw_done |= bus.ext_m_done; end
        check("m_rst_no_done", saw_done, 0);

        wd = '0;
        wd[0 +: 32] = 32'h1122_3344; wd[32 +: 32] = 32'h5566_7788; wd[64 +: 32] = 32'h99AA_BBCC;
        sl = '0; sl[3:0] = 4'hF; sl[7:4] = 4'h3; sl[11:8] = 4'hC;
        slave_xfer(1'b1, 32'h8000, 3, 0, wd, sl);

        rp = '0;
        for (int i = 0; i < MB; i++) rp[i*DW +: DW] = i;
        bus.ext_s_rdata = rp;
        wd = '0;
        for (int i = 0; i < 4; i++) wd[i*DW +: DW] = 32'hA0 + i;
        fork
            master_xfer(1'b1, 32'h1000, 4, 4'hF, wd, -1, 0, 0, 0, '0);
            slave_xfer(1'b0, 32'h9000, MB + 1, 3, '0, '0);
        join

        for (int t = 0; t < 24; t++) begin
            n = $urandom_range(0, 15);
            eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
            bus.ext_s_rdata = rand_ew();
            fork
                master_xfer($urandom_range(0, 1), $urandom & ~32'h3, LW'(n), 4'($urandom),
                            rand_ew(), eb, 0, 3, 0, '0);
                slave_xfer($urandom_range(0, 1), $urandom & ~32'h3, $urandom_range(1, MB),
                           $urandom_range(0, 3), rand_ew(), MB*SW'($urandom));
            join
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_fuzz_bridge_v2.md
Name: wb_fuzz_bridge_v2

Overview:
Parametrised dual-role Wishbone B4 bridge between the central fuzzer and a DUT bus.
- The master side issues fuzzer-programmed bursts of runtime-selectable length (1..MAX_BURST) with byte selects, ERR handling and a per-beat timeout watchdog.
- The slave side serves DUT-initiated bursts of any length up to MAX_BURST, with byte-masked capture, and reports each completed transaction to the fuzzer.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, bus data width (multiple of 8); address step per beat = DATA_WIDTH/8
MAX_BURST, 8, max beats per burst (≥1); ext data width EW = MAX_BURST*DATA_WIDTH; LW = $clog2(MAX_BURST+1)
TIMEOUT_CYCLES, 256, master cycles waited per beat for ACK/ERR before abort (≥2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  master bus controls
wbm_adr_o  out  ADDR_WIDTH  master address
wbm_dat_o  out  DATA_WIDTH  master write data
wbm_sel_o  out  DATA_WIDTH/8  master byte select
wbm_cti_o  out  3  master cycle type
wbm_bte_o  out  2  master burst type (constant 00)
wbm_dat_i  in  DATA_WIDTH  master read data
wbm_ack_i, wbm_err_i  in  1 each  master termination
wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  slave bus controls
wbs_adr_i  in  ADDR_WIDTH  slave address
wbs_dat_i  in  DATA_WIDTH  slave write data
wbs_sel_i  in  DATA_WIDTH/8  slave byte select
wbs_cti_i  in  3  slave cycle type
wbs_dat_o  out  DATA_WIDTH  slave read data
wbs_ack_o, wbs_err_o  out  1 each  slave termination
ext_m_req  in  1  fuzzer command strobe
ext_m_ready  out  1  master FSM idle, able to accept a command
ext_m_we  in  1  1 = write burst
ext_m_addr  in  ADDR_WIDTH  burst start address
ext_m_len  in  LW  beat count; 0 is treated as 1, values >MAX_BURST are clamped to MAX_BURST
ext_m_sel  in  DATA_WIDTH/8  byte select applied to every beat
ext_m_wdata  in  EW  write beats; beat i = bits [i*DATA_WIDTH +: DATA_WIDTH]
ext_m_rdata  out  EW  read beats, same packing
ext_m_done  out  1  one-cycle completion pulse
ext_m_err  out  1  valid with ext_m_done; set on ERR or timeout
ext_m_beats  out  LW  beats acknowledged, valid with ext_m_done
ext_s_rdata  in  EW  data returned to the DUT on slave reads, sampled live per beat
ext_s_valid  out  1  one-cycle pulse: slave transaction finished
ext_s_we  out  1  direction of the reported transaction
ext_s_addr  out  ADDR_WIDTH  first-beat address of the reported transaction
ext_s_len  out  LW  beats acknowledged in the reported transaction
ext_s_wdata  out  EW  captured write beats

Behaviour:
- Reset values:
  - All outputs 0, except wbm_sel_o = all ones and ext_m_ready = 1.
  - Both FSMs go to IDLE.
  - Reset mid-burst drops wbm_cyc_o/wbm_stb_o and wbs_ack_o immediately.
  - No done/valid pulse is generated for the interrupted burst.
- Master FSM: M_IDLE -> M_BUS -> M_DONE -> M_IDLE.
  - M_IDLE:
    - ext_m_ready = 1.
    - ext_m_req latches we/addr/len/sel/wdata, clears the rdata buffer and beat counter, and enters M_BUS.
    - ext_m_ready falls on the next cycle.
  - M_BUS, first cycle: cyc = stb = 1, adr = start address, dat = beat 0, we and sel as latched.
  - cti = 010 on non-final beats; 111 on the final beat, including single-beat bursts.
  - On ack:
    - Store wbm_dat_i into rdata beat idx (reads).
    - Increment idx and the address by DATA_WIDTH/8, with modulo 2^ADDR_WIDTH wrap.
    - Present the next write beat.
    - On the final beat, deassert cyc/stb at the same edge and go to M_DONE.
  - On err:
    - Deassert cyc/stb and go to M_DONE with err = 1.
    - Beats already acked are kept; unacked read beats are 0.
  - ack and err together: err wins.
  - Timeout:
    - A per-beat counter increments while cyc is high and is cleared on ack.
    - When it reaches TIMEOUT_CYCLES, abort exactly as for err.
  - M_DONE:
    - ext_m_done = 1 for one cycle; ext_m_rdata, ext_m_err and ext_m_beats are updated at the same time and held until the next done.
    - Then return to M_IDLE.
  - ext_m_req outside M_IDLE is ignored.
- Slave FSM: S_IDLE, S_ACTIVE, S_REPORT.
  - A beat is accepted when cyc & stb & !ack in S_IDLE or S_ACTIVE.
  - On the first beat, latch we and adr, clear the capture buffer, and enter S_ACTIVE.
  - Each accepted beat gets a registered one-cycle wbs_ack_o pulse, giving a minimum of 2 cycles per beat.
    - Read beat: wbs_dat_o = ext_s_rdata beat idx, registered with the ack.
    - Write beat: for each byte with wbs_sel_i set, store wbs_dat_i into capture beat idx; unselected bytes stay 0.
  - Burst end is the accepted beat whose wbs_cti_i is 000 or 111; ack that beat, then go to S_REPORT.
  - cyc dropped in S_ACTIVE between beats: go to S_REPORT with the beats acked so far.
  - Beat MAX_BURST+1 of an unterminated burst:
    - Respond with one-cycle wbs_err_o instead of ack and store nothing.
    - Go to S_REPORT with len = MAX_BURST.
  - S_REPORT:
    - ext_s_valid = 1 for one cycle; ext_s_we/addr/len/wdata are updated at the same time and held until the next report.
    - Then go to S_IDLE.
    - No ack is issued in this cycle, so a back-to-back DUT request waits one cycle.
- The master and slave FSMs are fully independent and may be active simultaneously.

Test Plan:
1. Master write, len = 4, addr 0x1000, sel = F, wdata beats A0..A3, ack every cycle:
   - adr 0x1000/1004/1008/100C; cti 010,010,010,111; dat A0..A3.
   - ext_m_done with err = 0, beats = 4.
2. Master read, len = 1, addr 0xFFFF_FFFC, dat_i 0x5A5A5A5A:
   - cti = 111, one beat.
   - rdata beat0 = 0x5A5A5A5A, other beats 0; beats = 1.
3. Master read, len = 8, err asserted on beat 3:
   - cyc drops at the same edge.
   - done with err = 1, beats = 3; beats 0-2 valid, beats 3-7 zero.
4. Master write, no ack, TIMEOUT_CYCLES = 16:
   - Abort after 16 cycles of cyc high.
   - ext_m_err = 1, beats = 0.
   - Reassert rst mid-burst on a retry -> cyc = 0 immediately, ready = 1, no done pulse.
5. Slave write burst of 3 beats, cti 010,010,111, sel F/3/C, data 11223344/55667788/99AABBCC:
   - Three ack pulses.
   - ext_s_valid with len = 3; wdata beats 11223344/00007788/99AA0000.
6. Slave read with cti 010 held for 9 beats, ext_s_rdata beat i = i:
   - dat_o 0..7 with 8 acks, then wbs_err_o on the 9th beat.
   - ext_s_len = 8.
   - Concurrently run scenario 1 on the master side -> both complete correctly.
